coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end coin validator that sits directly upstream of the vending machine FSM. It synchronises and debounces a raw optical coin-sense line and measures how long each coin blocks the beam. It classifies the coin by that duration and emits exactly one single-cycle nickel, dime or quarter pulse, which is the pulse format the vending FSM consumes. Invalid, jammed or disallowed coins produce a reject pulse instead, so the coin is returned.

Parameters:
SYNC_STAGES, 2, synchroniser flop count on coin_sense (>=2)
DEB_CYCLES, 4, consecutive agreeing samples needed to change debounced level
CNT_W, 8, width of duration counter; MAX_LEN must be <= 2^CNT_W-1
DIME_MIN, 20, min debounced width (cycles) for dime, inclusive
DIME_MAX, 39, max width for dime, inclusive
NICKEL_MIN, 40, min width for nickel
NICKEL_MAX, 59, max width for nickel
QUARTER_MIN, 60, min width for quarter
QUARTER_MAX, 99, max width for quarter
MAX_LEN, 200, width at which a jam is declared
GAP_CYCLES, 8, holdoff after any result

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
coin_sense  input  1  raw asynchronous beam-blocked level, 1 = coin present
accept_en  input  1  1 = coins may be credited; sampled in the classify cycle
nickel  output  1  one-cycle pulse, nickel accepted
dime  output  1  one-cycle pulse, dime accepted
quarter  output  1  one-cycle pulse, quarter accepted
reject  output  1  one-cycle pulse, coin returned
jam  output  1  level, high while a jam is in progress
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0. Synchroniser flops, debounced level coin_db and all counters are 0. FSM enters IDLE.
- Synchroniser: coin_sense passes through SYNC_STAGES flops to give s.
- Debounce: coin_db toggles once s has differed from coin_db for DEB_CYCLES consecutive cycles. Any agreeing sample clears the debounce counter.
  - Latency from a raw edge to coin_db is SYNC_STAGES+DEB_CYCLES cycles.
  - A clean raw pulse of D >= DEB_CYCLES cycles yields a coin_db pulse of D cycles.
  - Glitches shorter than DEB_CYCLES are invisible.
- Width counter: loads 1 on the first coin_db-high cycle and increments each further high cycle. It saturates at MAX_LEN.
- FSM states:
  - IDLE: on coin_db=1 go to MEASURE.
  - MEASURE: on coin_db=0 go to CLASSIFY. If the count reaches MAX_LEN, go to JAM.
  - CLASSIFY (1 cycle): compare width against the inclusive windows, then go to HOLDOFF.
    - If accept_en=1, pulse the matching output.
    - If no window matches or accept_en=0, pulse reject.
  - JAM: jam=1. When coin_db=0, pulse reject and go to HOLDOFF. jam drops in the same cycle reject pulses.
  - HOLDOFF: count GAP_CYCLES cycles, then go to IDLE.
    - If coin_db=1 on expiry, go to JAM-RELEASE instead.
  - JAM-RELEASE: wait for coin_db=0, pulse reject, go to HOLDOFF. jam stays 0 in this state.
- Result pulses (nickel/dime/quarter/reject):
  - Registered, mutually exclusive, exactly one per coin, exactly one cycle wide.
  - Asserted in the cycle after coin_db first reads 0, i.e. SYNC_STAGES+DEB_CYCLES+1 cycles after the raw falling edge.
- Windows must not overlap; overlap is a parameter error with undefined behaviour. Width 0 is impossible.
- accept_en only matters in the CLASSIFY cycle. Changes during MEASURE have no effect.
- Reset mid-coin aborts with no pulse. If coin_sense is still high after release, the remaining portion is measured as a new coin.

Test Plan:
1. rst_n=0 with coin_sense=1, then release with coin_sense=0 -> all outputs stay 0, busy=0.
2. Clean 30-cycle raw pulse, accept_en=1 -> single dime pulse exactly 7 cycles after raw fall, no other output. Repeat with 50 -> nickel; repeat with 75 -> quarter.
3. Boundary widths:
   - 19 -> reject
   - 20 -> dime
   - 39 -> dime
   - 40 -> nickel
   - 59 -> nickel
   - 60 -> quarter
   - 99 -> quarter
   - 100 -> reject
4. 3-cycle raw glitch -> no output, busy stays 0. 30-cycle coin with a 2-cycle low glitch mid-pulse -> one dime.
5. 250-cycle pulse -> jam rises when the count hits 200 and stays high until coin_db falls, then a one-cycle reject. 50-cycle coin with accept_en=0 -> reject only.
6. Second coin rising 3 cycles after the first result pulse and held 40 cycles -> first coin credited, second rejected via JAM-RELEASE after it clears. Assert reset mid-MEASURE -> no pulse, outputs 0.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin front-end: synchronises and debounces the beam-sense line, times each coin,
// and issues one nickel/dime/quarter/reject pulse per coin for the vending FSM.
module coin_acceptor #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8,
  parameter int DIME_MIN    = 20,
  parameter int DIME_MAX    = 39,
  parameter int NICKEL_MIN  = 40,
  parameter int NICKEL_MAX  = 59,
  parameter int QUARTER_MIN = 60,
  parameter int QUARTER_MAX = 99,
  parameter int MAX_LEN     = 200,
  parameter int GAP_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin_sense,
  input  logic accept_en,
  output logic nickel,
  output logic dime,
  output logic quarter,
  output logic reject,
  output logic jam,
  output logic busy
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, MEASURE, CLASSIFY, JAMMED, HOLDOFF, JAM_RELEASE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic                   coin_db;
  logic [DEB_W-1:0]       deb_cnt;
  logic [CNT_W-1:0]       width;
  logic [CNT_W-1:0]       width_inc;
  logic [GAP_W-1:0]       gap_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] w);
    return (w >= CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : w + 1'b1;
  endfunction

  function automatic logic in_win(input logic [CNT_W-1:0] w, input int lo, input int hi);
    return (w >= CNT_W'(lo)) && (w <= CNT_W'(hi));
  endfunction

  // Result vector ordered {nickel, dime, quarter, reject}.
  function automatic logic [3:0] classify(input logic [CNT_W-1:0] w, input logic acc);
    if (!acc)                                 return 4'b0001;
    else if (in_win(w, NICKEL_MIN, NICKEL_MAX))   return 4'b1000;
    else if (in_win(w, DIME_MIN, DIME_MAX))       return 4'b0100;
    else if (in_win(w, QUARTER_MIN, QUARTER_MAX)) return 4'b0010;
    else                                      return 4'b0001;
  endfunction

  assign s         = sync_p0[SYNC_STAGES-1];
  assign width_inc = sat_inc(width);

  // Stage p0: synchroniser and debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      coin_db <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], coin_sense};
      if (s != coin_db) begin
        if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
          coin_db <= s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Stage p1: width measurement and classification FSM; the result pulse is
  // registered on the MEASURE exit edge so it is high during CLASSIFY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      width   <= '0;
      gap_cnt <= '0;
      nickel  <= 1'b0;
      dime    <= 1'b0;
      quarter <= 1'b0;
      reject  <= 1'b0;
      jam     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      {nickel, dime, quarter, reject} <= 4'b0000;
      busy <= 1'b1;
      case (state)
        IDLE: begin
          if (coin_db) begin
            width <= CNT_W'(1);
            state <= MEASURE;
          end else begin
            busy <= 1'b0;
          end
        end
        MEASURE: begin
          if (!coin_db) begin
            {nickel, dime, quarter, reject} <= classify(width, accept_en);
            state <= CLASSIFY;
          end else begin
            width <= width_inc;
            if (width_inc == CNT_W'(MAX_LEN)) begin
              jam   <= 1'b1;
              state <= JAMMED;
            end
          end
        end
        CLASSIFY: begin
          gap_cnt <= '0;
          state   <= HOLDOFF;
        end
        JAMMED: begin
          if (!coin_db) begin
            reject  <= 1'b1;
            jam     <= 1'b0;
            gap_cnt <= '0;
            state   <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            if (coin_db) begin
              state <= JAM_RELEASE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        JAM_RELEASE: begin
          if (!coin_db) begin
            reject  <= 1'b1;
            gap_cnt <= '0;
            state   <= HOLDOFF;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: each coin pushes its expected pulse kind and
// cycle; a negedge monitor pops and compares whenever a result pulse appears.
module tb_coin_acceptor;

  localparam logic [3:0] K_N = 4'b1000;
  localparam logic [3:0] K_D = 4'b0100;
  localparam logic [3:0] K_Q = 4'b0010;
  localparam logic [3:0] K_R = 4'b0001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic coin_sense = 1'b0;
  logic accept_en = 1'b1;
  logic nickel, dime, quarter, reject, jam, busy;

  typedef struct {
    logic [3:0] kind;
    int         at;
  } exp_t;

  exp_t       sb[$];
  exp_t       ev;
  logic [3:0] pv;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;

  coin_acceptor dut (
    .clk(clk), .rst_n(rst_n), .coin_sense(coin_sense), .accept_en(accept_en),
    .nickel(nickel), .dime(dime), .quarter(quarter), .reject(reject),
    .jam(jam), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference classification from the raw pulse length.
  function automatic logic [3:0] model(input int d, input bit acc);
    if (d >= 200)            return K_R;
    if (!acc)                return K_R;
    if (d >= 20 && d <= 39)  return K_D;
    if (d >= 40 && d <= 59)  return K_N;
    if (d >= 60 && d <= 99)  return K_Q;
    return K_R;
  endfunction

  task automatic expect_at(input logic [3:0] k, input int at);
    exp_t e;
    e.kind = k;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
    check("busy_idle", busy, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic coin(input int d, input bit acc);
    accept_en  = acc;
    coin_sense = 1'b1;
    repeat (d) @(negedge clk);
    coin_sense = 1'b0;
    expect_at(model(d, acc), cyc + 7);
    settle();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      pv = {nickel, dime, quarter, reject};
      if (pv != 4'b0000) begin
        check("onehot", $countones(pv), 1);
        if (sb.size() == 0) begin
          check("unexpected_pulse", pv, 0);
        end else begin
          ev = sb.pop_front();
          check("pulse_kind", pv, ev.kind);
          check("pulse_cycle", cyc, ev.at);
        end
      end
    end
  end

  initial begin
    int widths[8] = '{19, 20, 39, 40, 59, 60, 99, 100};
    bit saw_busy;

    #1 rst_n = 1'b0;
    coin_sense = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {nickel, dime, quarter, reject, jam, busy}, 0);
    coin_sense = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (15) @(negedge clk);
    check("post_reset_outs", {nickel, dime, quarter, reject, jam, busy}, 0);

    coin(30, 1'b1);
    coin(50, 1'b1);
    coin(75, 1'b1);
    foreach (widths[i]) coin(widths[i], 1'b1);

    // Short glitch never reaches the debounced level
    saw_busy = 1'b0;
    coin_sense = 1'b1;
    repeat (3) @(negedge clk);
    coin_sense = 1'b0;
    repeat (15) begin
      @(negedge clk);
      saw_busy |= busy;
    end
    check("glitch_busy", saw_busy, 0);

    // 30-cycle coin with a 2-cycle dropout in the middle
    coin_sense = 1'b1;
    repeat (14) @(negedge clk);
    coin_sense = 1'b0;
    repeat (2) @(negedge clk);
    coin_sense = 1'b1;
    repeat (14) @(negedge clk);
    coin_sense = 1'b0;
    expect_at(K_D, cyc + 7);
    settle();

    // Jam: 250-cycle blockage
    accept_en  = 1'b1;
    coin_sense = 1'b1;
    repeat (205) @(negedge clk);
    check("jam_before", jam, 0);
    @(negedge clk);
    check("jam_rise", jam, 1);
    repeat (44) @(negedge clk);
    coin_sense = 1'b0;
    expect_at(K_R, cyc + 7);
    repeat (6) @(negedge clk);
    check("jam_hold", jam, 1);
    @(negedge clk);
    check("jam_fall", jam, 0);
    settle();

    coin(50, 1'b0);

    // Second coin blocks the beam before the holdoff expires
    accept_en  = 1'b1;
    coin_sense = 1'b1;
    repeat (30) @(negedge clk);
    coin_sense = 1'b0;
    expect_at(K_D, cyc + 7);
    repeat (4) @(negedge clk);
    coin_sense = 1'b1;
    repeat (40) @(negedge clk);
    check("jrel_jam_low", jam, 0);
    check("jrel_busy", busy, 1);
    coin_sense = 1'b0;
    expect_at(K_R, cyc + 7);
    settle();

    // Reset mid-measure aborts the coin
    coin_sense = 1'b1;
    repeat (20) @(negedge clk);
    check("measure_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outs", {nickel, dime, quarter, reject, jam, busy}, 0);
    coin_sense = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_idle", {nickel, dime, quarter, reject, jam, busy}, 0);

    check("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
